bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Read-side sequencer for the banked BRAM store. It takes a base address and a word count, issues single-cycle read strobes into the BRAM's one-cycle-latency read port, and buffers the returned words in a 2-entry FIFO. It presents them on a valid/ready stream with a last-beat marker. It sits between the BRAM and downstream consumers such as the UART/SPI dump path or the bitstream loader, and throttles reads so no returned word is ever dropped under backpressure.

## Interface
- NUM_BLOCKS, 16, number of 256×16 BRAM blocks; must match the BRAM instance.
- ADDR_BITS (localparam), 8 + $clog2(NUM_BLOCKS), word address width.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_BITS  first word address; sampled with start.
- length  in  ADDR_BITS+1  word count, 0..256*NUM_BLOCKS; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- mem_rd_en  out  1  BRAM read strobe.
- mem_rd_addr  out  ADDR_BITS  BRAM read address.
- mem_data  in  16  BRAM read data.
- mem_valid  in  1  BRAM read-data valid, one cycle after mem_rd_en.
- m_data  out  16  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; a beat transfers when m_valid && m_ready.
- m_last  out  1  marks the final beat; qualified by m_valid.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on start with length≠0, latch base_addr into the issue address, latch length into the issue and send counters, go to READ, busy←1. On start with length=0: no reads, busy stays 0, done=1 next cycle.
- start outside IDLE is ignored.
- READ: mem_rd_en=1 when the issue counter≠0 and (fifo_count + outstanding ≤ 1, or a beat pops this cycle). outstanding ≤ 1 at all times.
- Each issued read increments the issue address modulo 2^ADDR_BITS (wraps from the top address to 0) and decrements the issue counter. When the issue counter reaches 0, go to DRAIN.
- mem_valid with an outstanding read pushes mem_data into the FIFO. mem_valid without an outstanding read is ignored.
- The throttle rule guarantees a push never finds the FIFO full. Push and pop in the same cycle leave the count unchanged.
- m_valid = FIFO non-empty; m_data = FIFO head. Both are held stable while m_valid && !m_ready.
- m_last = m_valid && (send counter == 1). The send counter decrements on each transfer.
- DRAIN: on transfer of the last beat go to IDLE, busy←0, done=1 in the following cycle.
- rst in any state: state IDLE, counters and FIFO cleared, outstanding←0. A mem_valid arriving in the cycle after rst is discarded.

## Timing
- Reset values: busy 0, done 0, mem_rd_en 0, mem_rd_addr 0, m_valid 0, m_data 0, m_last 0.
- Start sampled at edge 0. Then:
  - mem_rd_en and first address high in cycle 1.
  - mem_valid in cycle 2.
  - m_valid in cycle 3.
- With m_ready held high, throughput is one word per cycle. N words finish their last transfer in cycle N+2; done in cycle N+3.
- busy is high from cycle 1 through the last-transfer cycle inclusive, and low while done is high.
- A new start is accepted in the done cycle.
- m_ready low: at most 2 words are buffered. mem_rd_en stays low until space frees, with no loss and no duplication.

## Test plan
- Memory preloaded with data = address. start, base 0x010, length 4, m_ready=1 → beats 0x0010..0x0013, m_last on 0x0013, done in cycle 7, exactly 4 mem_rd_en pulses.
- base 0xFFE, length 4, NUM_BLOCKS=16 → reads at 0xFFE, 0xFFF, 0x000, 0x001, in order.
- length 8, m_ready random (~50% duty) → all 8 words in order, none dropped or repeated, m_data stable under stall, FIFO never overflows.
- start with length 0 → no mem_rd_en, no m_valid, done one cycle later, busy stays 0. A second start while busy during a length-16 transfer is ignored.
- rst asserted the cycle after a mem_rd_en mid-transfer → all outputs at reset values next cycle, stray mem_valid ignored. A subsequent start, base 0x020, length 2, returns exactly 0x0020, 0x0021.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Read sequencer for the banked BRAM store: issues throttled single-word reads into a
// one-cycle-latency port and streams the returned words out through a 2-entry FIFO.
module bram_stream_reader #(
    parameter int unsigned NUM_BLOCKS = 16,
    localparam int unsigned ADDR_BITS = 8 + $clog2(NUM_BLOCKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    input  logic [ADDR_BITS:0]   length_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_rd_en_o,
    output logic [ADDR_BITS-1:0] mem_rd_addr_o,
    input  logic [15:0]          mem_data_i,
    input  logic                 mem_valid_i,
    output logic [15:0]          m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o
);

    localparam int unsigned CntBits = ADDR_BITS + 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CntBits-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CntBits-1:0]   send_cnt_q, send_cnt_d;
    logic                 outstanding_q;
    logic                 done_q, done_d;
    logic [15:0]          fifo_mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           fifo_cnt_q;

    logic rd_en, push, pop, last_pop, accept, accept_zero;

    always_comb begin
        pop         = (fifo_cnt_q != 2'd0) && m_ready_i;
        push        = mem_valid_i && outstanding_q;
        last_pop    = pop && (send_cnt_q == CntBits'(1));
        accept      = (state_q == StIdle) && start_i && (length_i != '0);
        accept_zero = (state_q == StIdle) && start_i && (length_i == '0);
        // Occupancy counts the in-flight word so a return never finds the FIFO full.
        rd_en = (state_q == StRead) && (issue_cnt_q != '0) &&
                (((fifo_cnt_q + {1'b0, outstanding_q}) <= 2'd1) || pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  if (rd_en && (issue_cnt_q == CntBits'(1))) state_d = StDrain;
            StDrain: if (last_pop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != StIdle);
        done_o        = done_q;
        mem_rd_en_o   = rd_en;
        mem_rd_addr_o = addr_q;
        m_valid_o     = (fifo_cnt_q != 2'd0);
        m_data_o      = fifo_mem_q[rd_ptr_q];
        m_last_o      = m_valid_o && (send_cnt_q == CntBits'(1));
    end

    always_comb begin
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        send_cnt_d  = send_cnt_q;
        if (accept) begin
            addr_d      = base_addr_i;
            issue_cnt_d = length_i;
            send_cnt_d  = length_i;
        end else begin
            if (rd_en) begin
                addr_d      = addr_q + ADDR_BITS'(1);
                issue_cnt_d = issue_cnt_q - CntBits'(1);
            end
            if (pop) begin
                send_cnt_d = send_cnt_q - CntBits'(1);
            end
        end
        done_d = accept_zero || ((state_q == StDrain) && last_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q        <= '0;
            issue_cnt_q   <= '0;
            send_cnt_q    <= '0;
            outstanding_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            issue_cnt_q   <= issue_cnt_d;
            send_cnt_q    <= send_cnt_d;
            outstanding_q <= rd_en;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= mem_data_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a data=address BRAM model behind it.
module tb_bram_stream_reader;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [15:0]   mem_data = '0;
    logic          mem_valid = 1'b0;
    logic [15:0]   m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] rd_addrs[$];
    logic [16:0]   beats[$];
    logic          stall_prev = 1'b0;
    logic [15:0]   stall_data = '0;
    int            cyc;

    always #5 clk = ~clk;

    bram_stream_reader #(.NUM_BLOCKS(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .base_addr_i   (base),
        .length_i      (length),
        .busy_o        (busy),
        .done_o        (done),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_data_i    (mem_data),
        .mem_valid_i   (mem_valid),
        .m_data_o      (m_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_last_o      (m_last)
    );

    // BRAM model: one-cycle latency, contents equal to the address.
    always @(posedge clk) begin
        mem_valid <= mem_rd_en;
        mem_data  <= 16'(mem_rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(stall_data));
            end
            if (mem_rd_en) rd_addrs.push_back(mem_rd_addr);
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
    endtask

    // Called with start driven in cycle 0; returns in cycle 1 with start released.
    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] n);
        rd_addrs.delete();
        beats.delete();
        base   = b;
        length = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int from, input int budget, input bit rnd, output int c);
        c = from;
        while (done !== 1'b1 && c < budget) begin
            tick();
            c++;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        check("done_within_budget", 32'(done), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
        m_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        check({tag, "_rd_count"}, 32'(rd_addrs.size()), 32'(n));
        check({tag, "_beat_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            if (i < rd_addrs.size())
                check($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_addrs[i]), 32'(a));
            if (i < beats.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(beats[i][15:0]), 32'(a));
                check($sformatf("%s_last%0d", tag, i), 32'(beats[i][16]), 32'(i == n - 1));
            end
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // Basic transfer: base 0x010, length 4, per-cycle timeline.
        start_xfer(12'h010, 13'd4);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 6));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 7));
            check($sformatf("t1_rd_en_c%0d", c), 32'(mem_rd_en), 32'(c <= 4));
            if (c <= 4)
                check($sformatf("t1_addr_c%0d", c), 32'(mem_rd_addr), 32'(12'h010 + c - 1));
            check($sformatf("t1_m_valid_c%0d", c), 32'(m_valid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6)
                check($sformatf("t1_m_data_c%0d", c), 32'(m_data), 32'(16'h0010 + c - 3));
            check($sformatf("t1_m_last_c%0d", c), 32'(m_last), 32'(c == 6));
        end
        check_beats("t1", 12'h010, 4);

        // Address wrap at the top of the store.
        start_xfer(12'hFFE, 13'd4);
        wait_done(1, 50, 1'b0, cyc);
        check("t2_done_cycle", 32'(cyc), 32'd7);
        check_beats("t2", 12'hFFE, 4);
        tick();

        // Hard stall: only two reads may be issued, head held stable.
        start_xfer(12'h040, 13'd6);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t3_stall_rd_count", 32'(rd_addrs.size()), 32'd2);
        check("t3_stall_rd_en", 32'(mem_rd_en), 32'd0);
        check("t3_stall_valid", 32'(m_valid), 32'd1);
        check("t3_stall_data", 32'(m_data), 32'h0040);
        check("t3_stall_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        wait_done(11, 100, 1'b0, cyc);
        check_beats("t3", 12'h040, 6);
        tick();

        // Random backpressure.
        start_xfer(12'h100, 13'd8);
        m_ready = 1'($urandom_range(0, 1));
        wait_done(1, 300, 1'b1, cyc);
        check_beats("t4", 12'h100, 8);
        tick();

        // Zero length: immediate done, no reads.
        start_xfer(12'h123, 13'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        check("t5_done_pulse", 32'(done), 32'd0);
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_rd_count", 32'(rd_addrs.size()), 32'd0);

        // Second start while busy is ignored.
        start_xfer(12'h200, 13'd16);
        tick();
        tick();
        base   = 12'h300;
        length = 13'd2;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(4, 100, 1'b0, cyc);
        check("t6_done_cycle", 32'(cyc), 32'd19);
        check_beats("t6", 12'h200, 16);
        tick();

        // Reset mid-transfer, stray read data must be dropped.
        start_xfer(12'h080, 13'd8);
        tick();
        check("t7_rd_en_c2", 32'(mem_rd_en), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("t7_after_rst");
        tick();
        check("t7_stray_ignored", 32'(m_valid), 32'd0);
        check("t7_idle_busy", 32'(busy), 32'd0);
        start_xfer(12'h020, 13'd2);
        wait_done(1, 50, 1'b0, cyc);
        check_beats("t7", 12'h020, 2);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
